pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and selects the next-PC source. It detects load-use hazards, taken branches and jumps resolved in MEM, arithmetic-overflow exceptions and data-memory wait states. It also keeps an exception PC and stall/redirect performance counters.

Parameters:
EXC_CYC, 2, drain cycles in S_EXC before redirecting to the exception vector (1..15).
MEM_TIMEOUT, 64, consecutive wait cycles after which Bus_err is set (1..255).
CNT_W, 16, width of the saturating performance counters.

Ports:
Clk  in  1  clock; all state updates on the falling edge, the same edge the pipeline registers use
Clr  in  1  synchronous reset, active-high
ID_Rs  in  5  source register rs of the instruction in ID
ID_Rt  in  5  source register rt of the instruction in ID
ID_UsesRt  in  1  ID instruction reads rt
EX_MemtoReg  in  1  instruction in EX is a load
EX_Rw  in  5  destination register of the instruction in EX
MEM_Branch  in  1  branch in MEM
MEM_Zero  in  1  branch condition in MEM
MEM_Jump  in  1  jump in MEM
MEM_Overflow  in  1  overflow flag in MEM
MEM_RegWr  in  1  MEM instruction writes a register
MEM_MemAcc  in  1  MEM instruction accesses data memory
MEM_PC  in  32  PC of the instruction in MEM
Dmem_ready  in  1  data memory completes this cycle
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
ID_EX_stall  out  1  hold ID/EX
EX_MEM_stall  out  1  hold EX/MEM
IF_ID_flush  out  1  bubble into IF/ID
ID_EX_flush  out  1  bubble into ID/EX
EX_MEM_flush  out  1  bubble into EX/MEM
MEM_WB_flush  out  1  bubble into MEM/WB
PC_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = exception vector
EPC  out  32  PC of the faulting instruction
Bus_err  out  1  sticky memory-timeout flag
Stall_cnt  out  CNT_W  cycles with PC_stall=1, saturating
Redir_cnt  out  CNT_W  redirect events (branch, jump, exception), saturating

Behaviour:
- Registered state: st ∈ {S_RUN, S_MWAIT, S_EXC}, 4-bit ecnt, 8-bit wcnt, EPC, Bus_err, both counters. Control outputs are combinational from st and the current inputs (Mealy).
- While Clr=1:
  - All stall/flush outputs are 0 and PC_src=0.
  - On the edge, st←S_RUN, ecnt/wcnt/EPC/Bus_err/counters←0.
- Event definitions:
  - mwait = MEM_MemAcc & !Dmem_ready
  - exc = MEM_Overflow & MEM_RegWr
  - taken = (MEM_Branch & MEM_Zero) | MEM_Jump
  - lu = EX_MemtoReg & EX_Rw≠0 & (EX_Rw==ID_Rs | (ID_UsesRt & EX_Rw==ID_Rt))
- S_RUN, evaluated in priority order mwait > exc > taken > lu:
  - mwait: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush = 1. st←S_MWAIT, wcnt←1.
  - exc: IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush and PC_stall = 1. EPC←MEM_PC, ecnt←EXC_CYC-1, st←S_EXC, Redir_cnt+1.
  - taken: IF_ID_flush, ID_EX_flush and EX_MEM_flush = 1. PC_src=2 if MEM_Jump, else 1 (jump wins if both are set). Redir_cnt+1.
  - lu: PC_stall, IF_ID_stall and ID_EX_flush = 1 for exactly one cycle. The load then leaves EX, so lu clears on its own.
  - none: all outputs 0, PC_src=0.
- S_MWAIT:
  - While !Dmem_ready: same freeze set as mwait. wcnt increments, saturating at 255. If wcnt==MEM_TIMEOUT on an edge, Bus_err←1 (sticky until Clr). Waiting continues; there is no abort.
  - When Dmem_ready=1: evaluate the S_RUN rules, excluding mwait, in the same cycle. st←S_RUN unless exc selects S_EXC; wcnt←0.
- S_EXC:
  - IF_ID_flush=1 and PC_stall=1.
  - When ecnt==0: PC_stall=0, PC_src=3, st←S_RUN. Otherwise ecnt-1.
  - Pipeline inputs are ignored in this state. Total exception latency is EXC_CYC+1 cycles from detection to vector fetch.
- Stall_cnt increments on every edge where PC_stall=1. Both counters saturate at 2^CNT_W-1, and Clr has priority over counting.
- Clr asserted mid-wait or mid-exception aborts the sequence; the next cycle is S_RUN with clean outputs.

Test Plan:
- Load-use: EX_MemtoReg=1, EX_Rw=5, ID_Rs=5 → one cycle with PC_stall=IF_ID_stall=ID_EX_flush=1, Stall_cnt=1. Repeat with EX_Rw=0 → no stall.
- Taken branch: MEM_Branch=1, MEM_Zero=1 → PC_src=1 with IF_ID/ID_EX/EX_MEM flush=1 for one cycle, Redir_cnt=1. MEM_Jump=1 with the branch also set → PC_src=2.
- Overflow: MEM_Overflow=1, MEM_RegWr=1, MEM_PC=0x0040_0010, EXC_CYC=2 → cycle 0: four flushes, EPC=0x0040_0010. Cycle 1: PC_stall. Cycle 2: PC_src=3, then S_RUN.
- Memory wait: MEM_MemAcc=1, Dmem_ready=0 for 3 cycles → 3 frozen cycles with MEM_WB_flush=1. Ready on cycle 4 → no freeze, Stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, Dmem_ready held 0 for 6 cycles → Bus_err=1 after the 4th wait edge and still 1 after release; it clears only on Clr.
- Priority and reset: mwait+exc in the same cycle → freeze only, and exc is taken on the ready cycle. Clr=1 in S_EXC → next cycle st=S_RUN, EPC=0, all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use stalls, MEM-resolved
// redirects, overflow exceptions, data-memory wait freezes, exception PC and perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned EXC_CYC     = 2,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemtoReg,
    input  logic [4:0]       EX_Rw,
    input  logic             MEM_Branch,
    input  logic             MEM_Zero,
    input  logic             MEM_Jump,
    input  logic             MEM_Overflow,
    input  logic             MEM_RegWr,
    input  logic             MEM_MemAcc,
    input  logic [31:0]      MEM_PC,
    input  logic             Dmem_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_stall,
    output logic             EX_MEM_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic [1:0]       PC_src,
    output logic [31:0]      EPC,
    output logic             Bus_err,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Redir_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_EXC   = 2'd2
    } state_t;

    localparam logic [3:0]       ECNT_INIT = 4'(EXC_CYC - 1);
    localparam logic [7:0]       TIMEOUT_V = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           st_q, st_d;
    logic [3:0]       ecnt_q, ecnt_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [31:0]      epc_q, epc_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    logic mwait_s, exc_s, taken_s, lu_s, freeze_s, redir_s;

    // Hazard event decode
    always_comb begin
        mwait_s = MEM_MemAcc & ~Dmem_ready;
        exc_s   = MEM_Overflow & MEM_RegWr;
        taken_s = (MEM_Branch & MEM_Zero) | MEM_Jump;
        lu_s    = EX_MemtoReg & (EX_Rw != 5'd0) &
                  ((EX_Rw == ID_Rs) | (ID_UsesRt & (EX_Rw == ID_Rt)));
        // once waiting, only Dmem_ready releases the freeze
        freeze_s = (st_q == S_MWAIT) ? ~Dmem_ready : mwait_s;
    end

    // Mealy control outputs and next-state computation
    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        PC_src       = 2'd0;
        st_d         = st_q;
        ecnt_d       = ecnt_q;
        wcnt_d       = wcnt_q;
        epc_d        = epc_q;
        bus_err_d    = bus_err_q;
        redir_s      = 1'b0;
        if (Clr) begin
            st_d = S_RUN;
        end else begin
            case (st_q)
                S_RUN, S_MWAIT: begin
                    if (freeze_s) begin
                        PC_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_stall = 1'b1;
                        MEM_WB_flush = 1'b1;
                        st_d         = S_MWAIT;
                        if (st_q == S_RUN) begin
                            wcnt_d = 8'd1;
                        end else if (wcnt_q != 8'hFF) begin
                            wcnt_d = wcnt_q + 8'd1;
                        end else begin
                            wcnt_d = wcnt_q;
                        end
                        if (wcnt_d == TIMEOUT_V) begin
                            bus_err_d = 1'b1;
                        end else begin
                            bus_err_d = bus_err_q;
                        end
                    end else if (exc_s) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        EX_MEM_flush = 1'b1;
                        MEM_WB_flush = 1'b1;
                        PC_stall     = 1'b1;
                        epc_d        = MEM_PC;
                        ecnt_d       = ECNT_INIT;
                        st_d         = S_EXC;
                        wcnt_d       = 8'd0;
                        redir_s      = 1'b1;
                    end else if (taken_s) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        EX_MEM_flush = 1'b1;
                        PC_src       = MEM_Jump ? 2'd2 : 2'd1;
                        st_d         = S_RUN;
                        wcnt_d       = 8'd0;
                        redir_s      = 1'b1;
                    end else if (lu_s) begin
                        PC_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        st_d         = S_RUN;
                        wcnt_d       = 8'd0;
                    end else begin
                        st_d         = S_RUN;
                        wcnt_d       = 8'd0;
                    end
                end
                S_EXC: begin
                    IF_ID_flush = 1'b1;
                    if (ecnt_q == 4'd0) begin
                        PC_src = 2'd3;
                        st_d   = S_RUN;
                    end else begin
                        PC_stall = 1'b1;
                        ecnt_d   = ecnt_q - 4'd1;
                    end
                end
                default: begin
                    st_d = S_RUN;
                end
            endcase
        end
    end

    // Saturating performance counter next values
    always_comb begin
        if (PC_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (redir_s && (redir_cnt_q != CNT_MAX)) begin
            redir_cnt_d = redir_cnt_q + CNT_ONE;
        end else begin
            redir_cnt_d = redir_cnt_q;
        end
    end

    // State registers update on the falling edge, in step with the pipeline registers
    always_ff @(negedge Clk) begin
        if (Clr) begin
            st_q        <= S_RUN;
            ecnt_q      <= 4'd0;
            wcnt_q      <= 8'd0;
            epc_q       <= 32'd0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            redir_cnt_q <= {CNT_W{1'b0}};
        end else begin
            st_q        <= st_d;
            ecnt_q      <= ecnt_d;
            wcnt_q      <= wcnt_d;
            epc_q       <= epc_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign EPC       = epc_q;
    assign Bus_err   = bus_err_q;
    assign Stall_cnt = stall_cnt_q;
    assign Redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expectations are queued as each cycle's stimulus
// is driven and checked at the rising edge, midway between the falling update edges.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Clr;
    logic [4:0]    ID_Rs, ID_Rt, EX_Rw;
    logic          ID_UsesRt, EX_MemtoReg;
    logic          MEM_Branch, MEM_Zero, MEM_Jump, MEM_Overflow, MEM_RegWr, MEM_MemAcc;
    logic [31:0]   MEM_PC;
    logic          Dmem_ready;
    logic          PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic          IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [1:0]    PC_src;
    logic [31:0]   EPC;
    logic          Bus_err;
    logic [CW-1:0] Stall_cnt, Redir_cnt;

    typedef struct packed {
        logic [3:0]    stl;
        logic [3:0]    fl;
        logic [1:0]    src;
        logic [31:0]   epc;
        logic          bus;
        logic [CW-1:0] sc;
        logic [CW-1:0] rc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [31:0]   exp_epc  = 32'd0;
    logic          exp_bus  = 1'b0;
    logic [CW-1:0] exp_sc   = '0;
    logic [CW-1:0] exp_rc   = '0;

    pipe_hazard_ctrl #(.EXC_CYC(2), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .Clk(Clk), .Clr(Clr), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemtoReg(EX_MemtoReg), .EX_Rw(EX_Rw), .MEM_Branch(MEM_Branch),
        .MEM_Zero(MEM_Zero), .MEM_Jump(MEM_Jump), .MEM_Overflow(MEM_Overflow),
        .MEM_RegWr(MEM_RegWr), .MEM_MemAcc(MEM_MemAcc), .MEM_PC(MEM_PC),
        .Dmem_ready(Dmem_ready), .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall),
        .ID_EX_stall(ID_EX_stall), .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .PC_src(PC_src), .EPC(EPC), .Bus_err(Bus_err), .Stall_cnt(Stall_cnt),
        .Redir_cnt(Redir_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        Clr = 1'b0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; EX_MemtoReg = 1'b0;
        EX_Rw = 5'd0; MEM_Branch = 1'b0; MEM_Zero = 1'b0; MEM_Jump = 1'b0;
        MEM_Overflow = 1'b0; MEM_RegWr = 1'b0; MEM_MemAcc = 1'b0; MEM_PC = 32'd0;
        Dmem_ready = 1'b1;
    endtask

    // stl = {PC, IF_ID, ID_EX, EX_MEM} stalls; fl = {IF_ID, ID_EX, EX_MEM, MEM_WB} flushes
    task automatic step(input string name, input logic [3:0] stl, input logic [3:0] fl,
                        input logic [1:0] src, input logic redir);
        exp_t e, got;
        e.stl = stl; e.fl = fl; e.src = src; e.epc = exp_epc; e.bus = exp_bus;
        e.sc = exp_sc; e.rc = exp_rc;
        sb.push_back(e);
        @(posedge Clk);
        e = sb.pop_front();
        got.stl = {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall};
        got.fl  = {IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};
        got.src = PC_src;
        n_checks += 5;
        if ({got.stl, got.fl, got.src} !== {e.stl, e.fl, e.src})
            $display("FAIL %s ctrl: stall=%b flush=%b src=%0d, expected stall=%b flush=%b src=%0d",
                     name, got.stl, got.fl, got.src, e.stl, e.fl, e.src);
        else n_pass++;
        if (EPC !== e.epc) $display("FAIL %s epc: got %h expected %h", name, EPC, e.epc);
        else n_pass++;
        if (Bus_err !== e.bus) $display("FAIL %s bus_err: got %b expected %b", name, Bus_err, e.bus);
        else n_pass++;
        if (Stall_cnt !== e.sc) $display("FAIL %s stall_cnt: got %0d expected %0d", name, Stall_cnt, e.sc);
        else n_pass++;
        if (Redir_cnt !== e.rc) $display("FAIL %s redir_cnt: got %0d expected %0d", name, Redir_cnt, e.rc);
        else n_pass++;
        @(negedge Clk);
        if (Clr) begin
            exp_sc = '0; exp_rc = '0; exp_epc = 32'd0; exp_bus = 1'b0;
        end else begin
            if (stl[3] && exp_sc != {CW{1'b1}}) exp_sc = exp_sc + 1'b1;
            if (redir && exp_rc != {CW{1'b1}}) exp_rc = exp_rc + 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Clr = 1'b1; MEM_Jump = 1'b1; MEM_MemAcc = 1'b1; Dmem_ready = 1'b0;
        @(negedge Clk); #1;
        step("reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs();
        step("reset_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_load_use();
        idle_inputs(); EX_MemtoReg = 1'b1; EX_Rw = 5'd5; ID_Rs = 5'd5;
        step("lu_rs", 4'b1100, 4'b0100, 2'd0, 1'b0);
        idle_inputs();
        step("lu_after", 4'b0000, 4'b0000, 2'd0, 1'b0);
        EX_MemtoReg = 1'b1; EX_Rw = 5'd0; ID_Rs = 5'd0;
        step("lu_r0", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs(); EX_MemtoReg = 1'b1; EX_Rw = 5'd7; ID_Rs = 5'd3; ID_Rt = 5'd7; ID_UsesRt = 1'b1;
        step("lu_rt", 4'b1100, 4'b0100, 2'd0, 1'b0);
        ID_UsesRt = 1'b0;
        step("lu_rt_unused", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs(); EX_Rw = 5'd5; ID_Rs = 5'd5;
        step("lu_not_load", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_branch();
        idle_inputs(); MEM_Branch = 1'b1; MEM_Zero = 1'b1;
        step("br_taken", 4'b0000, 4'b1110, 2'd1, 1'b1);
        MEM_Zero = 1'b0;
        step("br_not_taken", 4'b0000, 4'b0000, 2'd0, 1'b0);
        MEM_Zero = 1'b1; MEM_Jump = 1'b1;
        step("jump_and_br", 4'b0000, 4'b1110, 2'd2, 1'b1);
        idle_inputs(); MEM_Jump = 1'b1; EX_MemtoReg = 1'b1; EX_Rw = 5'd9; ID_Rs = 5'd9;
        step("jump_over_lu", 4'b0000, 4'b1110, 2'd2, 1'b1);
        idle_inputs();
        step("br_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_exception();
        idle_inputs(); MEM_Overflow = 1'b1;
        step("ovf_no_regwr", 4'b0000, 4'b0000, 2'd0, 1'b0);
        MEM_RegWr = 1'b1; MEM_PC = 32'h0040_0010; MEM_Jump = 1'b1;
        step("exc_detect", 4'b1000, 4'b1111, 2'd0, 1'b1);
        exp_epc = 32'h0040_0010;
        MEM_PC = 32'h0000_0BAD; MEM_MemAcc = 1'b1; Dmem_ready = 1'b0;
        step("exc_drain", 4'b1000, 4'b1000, 2'd0, 1'b0);
        step("exc_vector", 4'b0000, 4'b1000, 2'd3, 1'b0);
        idle_inputs();
        step("exc_done", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_mem_wait();
        idle_inputs(); MEM_MemAcc = 1'b1; Dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mwait_freeze", 4'b1111, 4'b0001, 2'd0, 1'b0);
        Dmem_ready = 1'b1;
        step("mwait_ready", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs();
        step("mwait_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_timeout();
        idle_inputs(); MEM_MemAcc = 1'b1; Dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step("timeout_wait", 4'b1111, 4'b0001, 2'd0, 1'b0);
            if (i == 4) exp_bus = 1'b1;
        end
        Dmem_ready = 1'b1; MEM_Branch = 1'b1; MEM_Zero = 1'b1;
        step("timeout_release_br", 4'b0000, 4'b1110, 2'd1, 1'b1);
        idle_inputs();
        step("timeout_sticky", 4'b0000, 4'b0000, 2'd0, 1'b0);
        Clr = 1'b1;
        step("timeout_clr", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs();
        step("timeout_cleared", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_priority();
        idle_inputs(); MEM_MemAcc = 1'b1; Dmem_ready = 1'b0; MEM_Overflow = 1'b1; MEM_RegWr = 1'b1;
        MEM_PC = 32'h0000_1234;
        step("prio_mwait_exc", 4'b1111, 4'b0001, 2'd0, 1'b0);
        Dmem_ready = 1'b1;
        step("prio_exc_on_ready", 4'b1000, 4'b1111, 2'd0, 1'b1);
        exp_epc = 32'h0000_1234;
        idle_inputs();
        step("prio_exc_drain", 4'b1000, 4'b1000, 2'd0, 1'b0);
        Clr = 1'b1;
        step("prio_clr_in_exc", 4'b0000, 4'b0000, 2'd0, 1'b0);
        idle_inputs();
        step("prio_after_clr", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        idle_inputs(); MEM_Branch = 1'b1; MEM_Zero = 1'b1;
        step("b2b_br1", 4'b0000, 4'b1110, 2'd1, 1'b1);
        step("b2b_br2", 4'b0000, 4'b1110, 2'd1, 1'b1);
        idle_inputs(); EX_MemtoReg = 1'b1; EX_Rw = 5'd2; ID_Rs = 5'd2;
        step("b2b_lu", 4'b1100, 4'b0100, 2'd0, 1'b0);
        idle_inputs(); MEM_MemAcc = 1'b1; Dmem_ready = 1'b0;
        step("b2b_wait", 4'b1111, 4'b0001, 2'd0, 1'b0);
        Dmem_ready = 1'b1; EX_MemtoReg = 1'b1; EX_Rw = 5'd4; ID_UsesRt = 1'b1; ID_Rt = 5'd4;
        step("b2b_ready_lu", 4'b1100, 4'b0100, 2'd0, 1'b0);
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            EX_MemtoReg = 1'b1; EX_Rw = 5'd1; ID_Rs = 5'd1;
            step("b2b_sat_lu", 4'b1100, 4'b0100, 2'd0, 1'b0);
            MEM_Jump = 1'b1; EX_MemtoReg = 1'b0;
            step("b2b_sat_jump", 4'b0000, 4'b1110, 2'd2, 1'b1);
            idle_inputs();
        end
        step("b2b_end", 4'b0000, 4'b0000, 2'd0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_exception();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
